cache_cmd_sched: RTL and testbench

Sequencer and arbiter that feeds the last-level cache model from two trace-command requesters: a CPU channel and a snoop channel. Each channel is buffered in its own FIFO. Snoops win arbitration, with a bounded-starvation rule for the CPU. The block keeps exactly one command outstanding at the cache and maintains the read/write/hit/miss statistics counters.

---
 rtl/cache_cmd_sched_if.sv | 33 +++
 rtl/cache_cmd_sched.sv | 174 +++++++++++++++++
 tb/tb_cache_cmd_sched.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_cmd_sched_if.sv
// Request/command bus of the cache command scheduler: CPU and snoop requester
// channels plus the single-outstanding command channel to the cache model.
interface cache_cmd_sched_if #(
  parameter int ADR_BITS = 32,
  parameter int CMD_BITS = 4
);
  logic                cpu_valid;
  logic                cpu_ready;
  logic [CMD_BITS-1:0] cpu_cmd;
  logic [ADR_BITS-1:0] cpu_addr;
  logic                snp_valid;
  logic                snp_ready;
  logic [CMD_BITS-1:0] snp_cmd;
  logic [ADR_BITS-1:0] snp_addr;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [CMD_BITS-1:0] cmd;
  logic [ADR_BITS-1:0] cmd_addr;
  logic                cmd_done;
  logic                cmd_hit;

  modport master (
    input  cpu_valid, cpu_cmd, cpu_addr, snp_valid, snp_cmd, snp_addr,
    input  cmd_ready, cmd_done, cmd_hit,
    output cpu_ready, snp_ready, cmd_valid, cmd, cmd_addr
  );

  modport slave (
    output cpu_valid, cpu_cmd, cpu_addr, snp_valid, snp_cmd, snp_addr,
    output cmd_ready, cmd_done, cmd_hit,
    input  cpu_ready, snp_ready, cmd_valid, cmd, cmd_addr
  );
endinterface

// File: rtl/cache_cmd_sched.sv
// Two-channel (CPU/snoop) command scheduler for the LLC model: per-channel FIFOs,
// snoop-priority arbitration with bounded CPU starvation, one command in flight.
module cache_cmd_sched #(
  parameter int ADR_BITS        = 32,
  parameter int CMD_BITS        = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_SNOOP_BURST = 3,
  parameter int CNT_BITS        = 32
) (
  input  logic                clk,
  input  logic                rst,
  cache_cmd_sched_if.master   bus,
  output logic                busy,
  output logic [CNT_BITS-1:0] rd_count,
  output logic [CNT_BITS-1:0] wr_count,
  output logic [CNT_BITS-1:0] hit_count,
  output logic [CNT_BITS-1:0] miss_count
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(MAX_SNOOP_BURST + 1);

  typedef struct packed {
    logic [CMD_BITS-1:0] op;
    logic [ADR_BITS-1:0] addr;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE} state_t;

  // channel index 0 = CPU, 1 = snoop
  logic [1:0] valid, push, pop, full, nonempty;
  entry_t     din  [2];
  entry_t     head [2];

  assign valid  = {bus.snp_valid, bus.cpu_valid};
  assign din[0] = '{bus.cpu_cmd, bus.cpu_addr};
  assign din[1] = '{bus.snp_cmd, bus.snp_addr};
  assign push   = valid & ~full;
  assign bus.cpu_ready = ~full[0];
  assign bus.snp_ready = ~full[1];

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    entry_t         mem [FIFO_DEPTH];
    logic [PW-1:0]  wp, rp;
    logic [CW-1:0]  cnt;

    always_ff @(posedge clk) begin
      if (push[g]) mem[wp] <= din[g];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (push[g]) wp <= (wp == PW'(FIFO_DEPTH - 1)) ? '0 : wp + 1'b1;
        if (pop[g])  rp <= (rp == PW'(FIFO_DEPTH - 1)) ? '0 : rp + 1'b1;
        case ({push[g], pop[g]})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end

    assign full[g]     = (cnt == CW'(FIFO_DEPTH));
    assign nonempty[g] = (cnt != '0);
    assign head[g]     = mem[rp];
  end

  state_t              state, state_nx;
  logic                grant_cpu, load, handshake, done;
  logic [SW-1:0]       streak;
  logic                cmd_valid_q;
  logic [CMD_BITS-1:0] cmd_q, src_op;
  logic [ADR_BITS-1:0] cmd_addr_q;
  logic                src_cpu;
  entry_t              gnt;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    pop       = '0;
    grant_cpu = 1'b0;
    load      = 1'b0;
    handshake = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (|nonempty) begin
          load     = 1'b1;
          state_nx = S_ISSUE;
          // CPU wins when snoops are absent or the snoop streak is exhausted
          if (nonempty[0] && (!nonempty[1] || streak == SW'(MAX_SNOOP_BURST))) begin
            grant_cpu = 1'b1;
            pop[0]    = 1'b1;
          end else begin
            pop[1]    = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (bus.cmd_ready) begin
          handshake = 1'b1;
          state_nx  = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (bus.cmd_done) begin
          done     = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign gnt = grant_cpu ? head[0] : head[1];

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
      cmd_addr_q  <= '0;
      src_op      <= '0;
      src_cpu     <= 1'b0;
      streak      <= '0;
      rd_count    <= '0;
      wr_count    <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      if (load) begin
        cmd_valid_q <= 1'b1;
        cmd_q       <= (gnt.op == CMD_BITS'(2)) ? '0 : gnt.op;
        cmd_addr_q  <= gnt.addr;
        src_op      <= gnt.op;
        src_cpu     <= grant_cpu;
        streak      <= (grant_cpu || !nonempty[0]) ? '0 : streak + 1'b1;
      end
      if (handshake) begin
        cmd_valid_q <= 1'b0;
        if (src_op == CMD_BITS'(8)) begin
          rd_count   <= '0;
          wr_count   <= '0;
          hit_count  <= '0;
          miss_count <= '0;
        end else if (src_op == CMD_BITS'(0) || src_op == CMD_BITS'(2)) begin
          rd_count <= sat_inc(rd_count);
        end else if (src_op == CMD_BITS'(1)) begin
          wr_count <= sat_inc(wr_count);
        end
      end
      if (done && src_cpu && src_op <= CMD_BITS'(2)) begin
        if (bus.cmd_hit) hit_count  <= sat_inc(hit_count);
        else             miss_count <= sat_inc(miss_count);
      end
    end
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd       = cmd_q;
  assign bus.cmd_addr  = cmd_addr_q;
  assign busy          = (state != S_IDLE);
endmodule

// File: tb/tb_cache_cmd_sched.sv
// Bench for cache_cmd_sched: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cache_cmd_sched;
  localparam int DEPTH = 4;
  localparam int MAXB  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [3:0] rd_count, wr_count, hit_count, miss_count;

  always #5 clk = ~clk;

  cache_cmd_sched_if #(.ADR_BITS(32), .CMD_BITS(4)) bus ();

  cache_cmd_sched #(
    .ADR_BITS(32), .CMD_BITS(4), .FIFO_DEPTH(DEPTH),
    .MAX_SNOOP_BURST(MAXB), .CNT_BITS(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy),
    .rd_count(rd_count), .wr_count(wr_count),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
  } ent_t;

  ent_t       qc[$], qs[$], e;
  bit         armed = 0;
  bit         m_pres, m_wait, m_src_cpu, acc_c, acc_s, take_cpu;
  int         m_streak;
  logic [3:0] m_src_op, e_cmd;
  logic [31:0] e_addr;
  logic [3:0] m_rd, m_wr, m_hit, m_miss;

  function automatic logic [3:0] sinc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      armed = 1; qc.delete(); qs.delete();
      m_pres = 0; m_wait = 0; m_src_cpu = 0; m_streak = 0;
      m_src_op = 0; e_cmd = 0; e_addr = 0;
      m_rd = 0; m_wr = 0; m_hit = 0; m_miss = 0;
    end else if (armed) begin
      acc_c = bus.cpu_valid && qc.size() < DEPTH;
      acc_s = bus.snp_valid && qs.size() < DEPTH;
      if (!m_pres && !m_wait) begin
        if (qc.size() > 0 || qs.size() > 0) begin
          take_cpu = qc.size() > 0 && (qs.size() == 0 || m_streak == MAXB);
          if (take_cpu) begin
            e = qc.pop_front(); m_streak = 0;
          end else begin
            e = qs.pop_front(); m_streak = (qc.size() > 0) ? m_streak + 1 : 0;
          end
          m_src_cpu = take_cpu; m_src_op = e.op;
          e_cmd = (e.op == 4'd2) ? 4'd0 : e.op; e_addr = e.addr; m_pres = 1;
        end
      end else if (m_pres) begin
        if (bus.cmd_ready) begin
          m_pres = 0; m_wait = 1;
          if (m_src_op == 4'd8) begin m_rd = 0; m_wr = 0; m_hit = 0; m_miss = 0; end
          else if (m_src_op == 4'd0 || m_src_op == 4'd2) m_rd = sinc(m_rd);
          else if (m_src_op == 4'd1) m_wr = sinc(m_wr);
        end
      end else if (bus.cmd_done) begin
        m_wait = 0;
        if (m_src_cpu && m_src_op <= 4'd2) begin
          if (bus.cmd_hit) m_hit = sinc(m_hit); else m_miss = sinc(m_miss);
        end
      end
      if (acc_c) qc.push_back('{bus.cpu_cmd, bus.cpu_addr});
      if (acc_s) qs.push_back('{bus.snp_cmd, bus.snp_addr});
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (armed) begin
      chk("cmd_valid", bus.cmd_valid, m_pres);
      chk("cmd", bus.cmd, e_cmd);
      chk("cmd_addr", bus.cmd_addr, e_addr);
      chk("busy", busy, m_pres | m_wait);
      chk("cpu_ready", bus.cpu_ready, qc.size() < DEPTH);
      chk("snp_ready", bus.snp_ready, qs.size() < DEPTH);
      chk("rd_count", rd_count, m_rd);
      chk("wr_count", wr_count, m_wr);
      chk("hit_count", hit_count, m_hit);
      chk("miss_count", miss_count, m_miss);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic reset_dut();
    bus.cpu_valid = 0; bus.cpu_cmd = 0; bus.cpu_addr = 0;
    bus.snp_valid = 0; bus.snp_cmd = 0; bus.snp_addr = 0;
    bus.cmd_ready = 0; bus.cmd_done = 0; bus.cmd_hit = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic push_cpu(input logic [3:0] c, input logic [31:0] a);
    logic r;
    logic acc;
    acc = 0;
    bus.cpu_valid = 1; bus.cpu_cmd = c; bus.cpu_addr = a;
    for (int i = 0; i < 100; i++) begin
      r = bus.cpu_ready;
      @(negedge clk);
      if (r) begin acc = 1; break; end
    end
    bus.cpu_valid = 0;
    chk("cpu_push_accept", acc, 1);
  endtask

  task automatic push_snp(input logic [3:0] c, input logic [31:0] a);
    logic r;
    logic acc;
    acc = 0;
    bus.snp_valid = 1; bus.snp_cmd = c; bus.snp_addr = a;
    for (int i = 0; i < 100; i++) begin
      r = bus.snp_ready;
      @(negedge clk);
      if (r) begin acc = 1; break; end
    end
    bus.snp_valid = 0;
    chk("snp_push_accept", acc, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (qc.size() == 0 && qs.size() == 0 && !m_pres && !m_wait) break;
      @(negedge clk);
    end
    chk("drain_busy", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [7:0] exp_pat;
  logic       pv;
  int         n;
  logic [3:0] rc, sc;

  initial begin
    reset_dut();
    chk("reset_cmd_valid", bus.cmd_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_cpu_ready", bus.cpu_ready, 1);
    chk("reset_snp_ready", bus.snp_ready, 1);

    // single CPU read-instruction: latency and counters
    bus.cmd_ready = 1;
    bus.cpu_valid = 1; bus.cpu_cmd = 4'd2; bus.cpu_addr = 32'h0000_1040;
    @(negedge clk); bus.cpu_valid = 0;
    chk("t1_n1_valid", bus.cmd_valid, 0);
    @(negedge clk);
    chk("t1_n2_valid", bus.cmd_valid, 1);
    chk("t1_n2_cmd", bus.cmd, 0);
    chk("t1_n2_addr", bus.cmd_addr, 32'h1040);
    chk("t1_n2_busy", busy, 1);
    @(negedge clk);
    chk("t1_n3_valid", bus.cmd_valid, 0);
    chk("t1_rd", rd_count, 1);
    chk("t1_model_rd", m_rd, 1);
    bus.cmd_done = 1; bus.cmd_hit = 1;
    @(negedge clk); bus.cmd_done = 0;
    chk("t1_hit", hit_count, 1);
    chk("t1_busy_fall", busy, 0);

    // CPU FIFO fill while the cache stalls, stall stability, ignored early done
    reset_dut();
    fork
      begin
        for (int i = 0; i < 6; i++) push_cpu(4'd0, 32'h100 + 32'(i) * 4);
      end
      begin
        repeat (10) @(negedge clk);
        chk("t2_full_ready", bus.cpu_ready, 0);
        for (int k = 0; k < 5; k++) begin
          bus.cmd_done = (k == 2);
          @(negedge clk);
          chk("t2_stall_valid", bus.cmd_valid, 1);
          chk("t2_stall_addr", bus.cmd_addr, 32'h100);
          chk("t2_stall_busy", busy, 1);
          chk("t2_stall_rd", rd_count, 0);
          chk("t2_stall_hit", hit_count, 0);
        end
        bus.cmd_hit = 0; bus.cmd_ready = 1; bus.cmd_done = 1;
      end
      begin
        pv = 0; n = 0;
        for (int t = 0; t < 120 && n < 6; t++) begin
          @(negedge clk);
          if (bus.cmd_valid && !pv) begin
            chk("t2_order_addr", bus.cmd_addr, 32'h100 + 32'(n) * 4);
            n++;
          end
          pv = bus.cmd_valid;
        end
        chk("t2_order_count", n, 6);
      end
    join
    drain();
    chk("t2_miss", miss_count, 6);

    // snoop priority with bounded CPU starvation
    reset_dut();
    bus.cmd_ready = 1; bus.cmd_done = 1; bus.cmd_hit = 1;
    exp_pat = 8'b1110_1110;
    fork
      begin for (int i = 0; i < 6; i++) push_snp(4'd4, 32'h2000 + 32'(i) * 4); end
      begin for (int i = 0; i < 2; i++) push_cpu(4'd0, 32'h3000 + 32'(i) * 4); end
      begin
        n = 0;
        for (int t = 0; t < 100 && n < 8; t++) begin
          @(negedge clk);
          if (bus.cmd_valid) begin
            chk("t3_grant_is_snoop", !bus.cmd_addr[12], exp_pat[7-n]);
            n++;
          end
        end
        chk("t3_grant_count", n, 8);
      end
    join
    drain();
    bus.cmd_done = 0;

    // counters, opcode-8 clear, opcode-9 pass-through
    reset_dut();
    bus.cmd_ready = 1; bus.cmd_done = 1; bus.cmd_hit = 1;
    push_cpu(4'd0, 32'h10); push_cpu(4'd2, 32'h14); push_cpu(4'd0, 32'h18);
    push_cpu(4'd1, 32'h1C); push_cpu(4'd1, 32'h20);
    drain();
    chk("t4_rd", rd_count, 3);
    chk("t4_wr", wr_count, 2);
    chk("t4_hit", hit_count, 5);
    chk("t4_model_wr", m_wr, 2);
    push_cpu(4'd8, 32'h24);
    drain();
    chk("t4_clr_rd", rd_count, 0);
    chk("t4_clr_wr", wr_count, 0);
    chk("t4_clr_hit", hit_count, 0);
    push_cpu(4'd9, 32'h28);
    drain();
    chk("t4_op9_cmd", bus.cmd, 9);
    chk("t4_op9_rd", rd_count, 0);
    chk("t4_op9_hit", hit_count, 0);

    // reset in WAIT_DONE with queued CPU work
    reset_dut();
    bus.cmd_ready = 1;
    push_cpu(4'd0, 32'h500); push_cpu(4'd0, 32'h504); push_cpu(4'd0, 32'h508);
    repeat (2) @(negedge clk);
    chk("t5_wait_busy", busy, 1);
    chk("t5_wait_valid", bus.cmd_valid, 0);
    chk("t5_wait_rd", rd_count, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("t5_rst_valid", bus.cmd_valid, 0);
    chk("t5_rst_cmd", bus.cmd, 0);
    chk("t5_rst_addr", bus.cmd_addr, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_rd", rd_count, 0);
    chk("t5_rst_ready", bus.cpu_ready, 1);
    bus.cmd_done = 1;
    @(negedge clk);
    bus.cmd_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t5_no_issue", bus.cmd_valid, 0);
    end

    // randomized traffic against the model
    for (int t = 0; t < 4000; t++) begin
      rc = 4'd0;
      case ($urandom_range(0, 6))
        0: rc = 4'd0; 1: rc = 4'd1; 2: rc = 4'd2; 3: rc = 4'd8;
        4: rc = 4'd9; 5: rc = 4'd7; default: rc = 4'd0;
      endcase
      sc = ($urandom_range(0, 5) == 0) ? 4'd12 : 4'($urandom_range(3, 6));
      bus.cpu_valid = ($urandom_range(0, 2) != 0);
      bus.cpu_cmd   = ($urandom_range(0, 30) == 0) ? 4'd8 : rc;
      bus.cpu_addr  = $urandom;
      bus.snp_valid = ($urandom_range(0, 2) == 0);
      bus.snp_cmd   = sc;
      bus.snp_addr  = $urandom;
      bus.cmd_ready = ($urandom_range(0, 9) < 7);
      bus.cmd_done  = ($urandom_range(0, 1) == 1);
      bus.cmd_hit   = ($urandom_range(0, 1) == 1);
      rst           = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    rst = 0; bus.cpu_valid = 0; bus.snp_valid = 0;
    bus.cmd_ready = 1; bus.cmd_done = 1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
